// File: rtl/box_filter_pkg.sv
// Shared sizing helpers and sideband types for the K x K box-sum filter.
// Also holds the reciprocal constants used when BOX_FILTER_NORM_EN is defined.
package box_filter_pkg;

    typedef struct packed {
        logic vld;
        logic eol;
    } tag_t;

    // Number of bits needed to represent value (0 -> 0, 8 -> 4, 127 -> 7).
    function automatic int clogb2(input longint value);
        longint v;
        int     n;
        v = value;
        for (n = 0; v > 64'sd0; n++) begin
            v = v >>> 1;
        end
        return n;
    endfunction

    function automatic int add_stages(input int k);
        return clogb2(longint'(k * k - 1));
    endfunction

    function automatic int sum_width(input int k, input int pw);
        return pw + add_stages(k);
    endfunction

    // Node count of an adder-tree level; odd leftovers ride along to the next level.
    function automatic int tree_nodes(input int n_in, input int lvl);
        int n;
        n = n_in;
        for (int i = 0; i < lvl; i++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    // Shift wide enough that (s + (K*K-1)/2) * RECIP >> SHIFT is exact for every s < 2^SUM_W.
    function automatic int norm_shift(input int k, input int pw);
        return sum_width(k, pw) + clogb2(longint'(k * k));
    endfunction

    function automatic longint recip(input int k, input int shift);
        longint d;
        d = longint'(k * k);
        return ((64'sd1 <<< shift) + d - 64'sd1) / d;
    endfunction

endpackage

// File: rtl/box_filter_kxk_adder_tree.sv
// Pipelined unsigned N-input adder tree; one register per level, width grows one bit per level.
// A valid/eol tag rides alongside; the final level only loads on a valid tag so its output holds.
module adder_tree_pipe
    import box_filter_pkg::*;
#(
    parameter int N_IN = 9,
    parameter int IN_W = 14
) (
    input  logic                                  clk,
    input  logic                                  arst,
    input  logic [N_IN*IN_W-1:0]                  din,
    input  tag_t                                  tag_in,
    output logic [IN_W+clogb2(longint'(N_IN-1))-1:0] dout,
    output tag_t                                  tag_out
);

    localparam int LEVELS = clogb2(longint'(N_IN - 1));

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int CNT = tree_nodes(N_IN, l);
        localparam int W   = IN_W + l;

        logic [W-1:0] node_s [CNT];
        tag_t         tag_s;

        if (l == 0) begin : g_src
            for (genvar i = 0; i < CNT; i++) begin : g_node
                assign node_s[i] = din[i*IN_W +: IN_W];
            end
            assign tag_s = tag_in;
        end else begin : g_add
            localparam int PCNT = tree_nodes(N_IN, l - 1);

            logic [W-1:0] sum_s  [CNT];
            logic [W-1:0] node_r [CNT];
            tag_t         tag_r;

            for (genvar i = 0; i < CNT; i++) begin : g_node
                if (2 * i + 1 < PCNT) begin : g_pair
                    assign sum_s[i] = W'(g_lvl[l-1].node_s[2*i]) + W'(g_lvl[l-1].node_s[2*i+1]);
                end else begin : g_odd
                    assign sum_s[i] = W'(g_lvl[l-1].node_s[2*i]);
                end
            end

            // level register; intermediate levels free-run, the last one loads only on valid
            always_ff @(posedge clk or posedge arst) begin
                if (arst) begin
                    for (int i = 0; i < CNT; i++) begin
                        node_r[i] <= '0;
                    end
                    tag_r <= '0;
                end else begin
                    tag_r <= g_lvl[l-1].tag_s;
                    if ((l < LEVELS) || g_lvl[l-1].tag_s.vld) begin
                        node_r <= sum_s;
                    end else begin
                        node_r <= node_r;
                    end
                end
            end

            assign node_s = node_r;
            assign tag_s  = tag_r;
        end
    end

    assign dout    = g_lvl[LEVELS].node_s[0];
    assign tag_out = g_lvl[LEVELS].tag_s;

endmodule

// File: rtl/box_filter_kxk.sv
// K x K box-sum filter fed one packed column per accepted beat; emits window sums with eol flag.
// Define BOX_FILTER_NORM_EN to output round-half-up(sum / (K*K)) after one extra stage.
module box_filter_kxk
    import box_filter_pkg::*;
#(
    parameter int KX_WIDTH    = 3,
    parameter int PIXEL_WIDTH = 14,
    parameter int IMAGE_WIDTH = 128
) (
    input  logic                                           clk,
    input  logic                                           arst,
    input  logic [KX_WIDTH*PIXEL_WIDTH-1:0]                data_in,
    input  logic                                           din_valid,
    input  logic                                           din_sol,
    output logic [PIXEL_WIDTH+add_stages(KX_WIDTH)-1:0]    data_out,
    output logic                                           dout_valid,
    output logic                                           dout_eol
);

    localparam int K          = KX_WIDTH;
    localparam int SUM_W      = sum_width(KX_WIDTH, PIXEL_WIDTH);
    localparam int CNT_WIDTH  = clogb2(longint'(IMAGE_WIDTH - 1));

    logic [CNT_WIDTH-1:0]   col_r;
    logic [CNT_WIDTH-1:0]   col_next_s;
    logic                   line_open_r;
    tag_t                   cap_tag_s;
    tag_t                   cap_tag_r;
    logic [PIXEL_WIDTH-1:0] win_r     [K][K];
    logic [PIXEL_WIDTH-1:0] win_nxt_s [K][K];
    logic [K*K*PIXEL_WIDTH-1:0] win_flat_s;
    logic [SUM_W-1:0]       tree_sum_s;
    tag_t                   tree_tag_s;

    // column index of the beat being accepted; a fresh line after reset starts at 0
    always_comb begin
        col_next_s = col_r;
        cap_tag_s  = '0;
        if (din_valid) begin
            if (din_sol || !line_open_r || (col_r == CNT_WIDTH'(IMAGE_WIDTH - 1))) begin
                col_next_s = '0;
            end else begin
                col_next_s = col_r + CNT_WIDTH'(1'b1);
            end
            cap_tag_s.vld = (col_next_s >= CNT_WIDTH'(K - 1));
            cap_tag_s.eol = cap_tag_s.vld && (col_next_s == CNT_WIDTH'(IMAGE_WIDTH - 1));
        end else begin
            col_next_s = col_r;
            cap_tag_s  = '0;
        end
    end

    // window column K-1 is the newest; each row is one image line
    for (genvar r = 0; r < K; r++) begin : g_row
        for (genvar c = 0; c < K; c++) begin : g_col
            if (c < K - 1) begin : g_shift
                assign win_nxt_s[r][c] = win_r[r][c+1];
            end else begin : g_load
                assign win_nxt_s[r][c] = data_in[r*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
            assign win_flat_s[(r*K+c)*PIXEL_WIDTH +: PIXEL_WIDTH] = win_r[r][c];
        end
    end

    // capture stage: window shift, column counter and tag, all gated by din_valid
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_r[r][c] <= '0;
                end
            end
            col_r       <= '0;
            line_open_r <= 1'b0;
            cap_tag_r   <= '0;
        end else begin
            if (din_valid) begin
                win_r       <= win_nxt_s;
                line_open_r <= 1'b1;
            end else begin
                win_r       <= win_r;
                line_open_r <= line_open_r;
            end
            col_r     <= col_next_s;
            cap_tag_r <= cap_tag_s;
        end
    end

    adder_tree_pipe #(
        .N_IN (K * K),
        .IN_W (PIXEL_WIDTH)
    ) u_tree (
        .clk     (clk),
        .arst    (arst),
        .din     (win_flat_s),
        .tag_in  (cap_tag_r),
        .dout    (tree_sum_s),
        .tag_out (tree_tag_s)
    );

`ifdef BOX_FILTER_NORM_EN
    localparam int     SHIFT  = norm_shift(KX_WIDTH, PIXEL_WIDTH);
    localparam longint RECIP  = recip(KX_WIDTH, SHIFT);
    localparam int     PROD_W = SHIFT + SUM_W;
    localparam int     HALF   = (K * K - 1) / 2;

    logic [PROD_W-1:0] prod_s;
    logic [SUM_W-1:0]  norm_r;
    logic              norm_vld_r;
    logic              norm_eol_r;

    assign prod_s = (PROD_W'(tree_sum_s) + PROD_W'(HALF)) * PROD_W'(RECIP);

    // normalise stage: quotient is below 2^PIXEL_WIDTH so the upper bits stay zero
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            norm_r     <= '0;
            norm_vld_r <= 1'b0;
            norm_eol_r <= 1'b0;
        end else begin
            norm_vld_r <= tree_tag_s.vld;
            norm_eol_r <= tree_tag_s.eol;
            if (tree_tag_s.vld) begin
                norm_r <= SUM_W'(prod_s >> SHIFT);
            end else begin
                norm_r <= norm_r;
            end
        end
    end

    assign data_out   = norm_r;
    assign dout_valid = norm_vld_r;
    assign dout_eol   = norm_eol_r;
`else
    assign data_out   = tree_sum_s;
    assign dout_valid = tree_tag_s.vld;
    assign dout_eol   = tree_tag_s.eol;
`endif

endmodule

// File: tb/tb_box_filter_kxk.sv
// Self-checking bench for box_filter_kxk (K=3, 14-bit pixels, 128 columns), raw or normalised build.
module tb_box_filter_kxk;

    localparam int K     = 3;
    localparam int P     = 14;
    localparam int IW    = 128;
    localparam int KK    = K * K;
    localparam int SUM_W = 18;
`ifdef BOX_FILTER_NORM_EN
    localparam int LAT  = 6;
    localparam bit NORM = 1'b1;
`else
    localparam int LAT  = 5;
    localparam bit NORM = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             arst;
    logic [K*P-1:0]   data_in;
    logic             din_valid;
    logic             din_sol;
    logic [SUM_W-1:0] data_out;
    logic             dout_valid;
    logic             dout_eol;

    box_filter_kxk #(
        .KX_WIDTH    (K),
        .PIXEL_WIDTH (P),
        .IMAGE_WIDTH (IW)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .data_in    (data_in),
        .din_valid  (din_valid),
        .din_sol    (din_sol),
        .data_out   (data_out),
        .dout_valid (dout_valid),
        .dout_eol   (dout_eol)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     due;
        longint val;
        bit     eol;
    } exp_t;

    typedef struct {
        int     base;
        int     spot;
        longint raw;
        longint nrm;
    } vec_t;

    exp_t           exp_q[$];
    logic [K*P-1:0] line_q[$];
    int             checks = 0;
    int             failures = 0;
    int             pulses = 0;
    int             eols = 0;
    int             eol_pulse = 0;
    int             first_cyc = 0;
    longint         hold_val = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic longint scale(input longint s);
        if (NORM) return (2 * s + KK) / (2 * KK);
        return s;
    endfunction

    // Reference: keep the current line's columns; each window is the last K of them.
    task automatic model_accept(input bit sol, input logic [K*P-1:0] colv);
        logic [K*P-1:0] c;
        longint         s;
        exp_t           e;
        if (sol || line_q.size() == IW) line_q.delete();
        line_q.push_back(colv);
        if (line_q.size() >= K) begin
            s = 0;
            for (int j = line_q.size() - K; j < line_q.size(); j++) begin
                c = line_q[j];
                for (int r = 0; r < K; r++) s += longint'(c[r*P +: P]);
            end
            e.due = cyc + LAT;
            e.val = scale(s);
            e.eol = (line_q.size() == IW);
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [K*P-1:0] rnd_col();
        logic [K*P-1:0] c;
        for (int r = 0; r < K; r++) c[r*P +: P] = P'($urandom);
        return c;
    endfunction

    function automatic logic [K*P-1:0] flat_col(input int v);
        logic [K*P-1:0] c;
        for (int r = 0; r < K; r++) c[r*P +: P] = P'(v);
        return c;
    endfunction

    task automatic beat(input bit v, input bit sol, input logic [K*P-1:0] d);
        @(posedge clk);
        #1;
        din_valid = v;
        din_sol   = sol;
        data_in   = d;
        if (v) model_accept(sol, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, rnd_col());
    endtask

    task automatic clear_counts();
        pulses = 0;
        eols = 0;
        eol_pulse = 0;
        first_cyc = 0;
    endtask

    // Output monitor: every due result must appear exactly then; otherwise valid low and data held.
    always @(negedge clk) begin
        if (arst) begin
            check("rst_data_out", data_out, 0);
            check("rst_dout_valid", dout_valid, 0);
            check("rst_dout_eol", dout_eol, 0);
        end else begin
            if (dout_valid) begin
                pulses++;
                if (pulses == 1) first_cyc = cyc;
                if (dout_eol) begin
                    eols++;
                    eol_pulse = pulses;
                end
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                check("out_valid", dout_valid, 1);
                check("out_data", data_out, exp_q[0].val);
                check("out_eol", dout_eol, exp_q[0].eol);
                hold_val = exp_q[0].val;
                void'(exp_q.pop_front());
            end else begin
                check("idle_valid", dout_valid, 0);
                check("hold_data", data_out, hold_val);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t           tbl[10];
        logic [K*P-1:0] col;
        int             t0;
        int             t2;

        arst      = 1'b1;
        din_valid = 1'b0;
        din_sol   = 1'b0;
        data_in   = '0;
        repeat (3) @(posedge clk);
        #1 arst = 1'b0;

        // single-window vectors: all pixels = base except line 0 of the oldest column = spot
        tbl[0] = '{100,   100,   900,    100};
        tbl[1] = '{0,     13,    13,     1};
        tbl[2] = '{0,     14,    14,     2};
        tbl[3] = '{16383, 16383, 147447, 16383};
        tbl[4] = '{0,     0,     0,      0};
        tbl[5] = '{0,     4,     4,      0};
        tbl[6] = '{0,     5,     5,      1};
        tbl[7] = '{2000,  0,     16000,  1778};
        tbl[8] = '{1,     5,     13,     1};
        tbl[9] = '{16383, 0,     131064, 14563};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < K; c++) begin
                col = flat_col(tbl[i].base);
                if (c == 0) col[P-1:0] = P'(tbl[i].spot);
                beat(1'b1, c == 0, col);
            end
            t0 = cyc;
            idle(1);
            while (cyc < t0 + LAT) @(negedge clk);
            check("tbl_valid", dout_valid, 1);
            check("tbl_sum", data_out, NORM ? tbl[i].nrm : tbl[i].raw);
            idle(2);
        end

        // continuous line of 100s
        clear_counts();
        t2 = 0;
        for (int c = 0; c < IW; c++) begin
            beat(1'b1, c == 0, flat_col(100));
            if (c == 2) t2 = cyc;
        end
        idle(LAT + 3);
        check("cont_pulses", pulses, IW - K + 1);
        check("cont_eols", eols, 1);
        check("cont_eol_pos", eol_pulse, IW - K + 1);
        check("cont_first_lat", first_cyc - t2, LAT);

        // continuous random line
        clear_counts();
        for (int c = 0; c < IW; c++) beat(1'b1, c == 0, rnd_col());
        idle(LAT + 3);
        check("rand_pulses", pulses, IW - K + 1);
        check("rand_eols", eols, 1);

        // gapped random line (1,0,0,...), idle cycles carry random sol that must be ignored
        clear_counts();
        for (int c = 0; c < IW; c++) begin
            beat(1'b1, c == 0, rnd_col());
            beat(1'b0, 1'($urandom_range(0, 1)), rnd_col());
            beat(1'b0, 1'($urandom_range(0, 1)), rnd_col());
        end
        idle(LAT + 3);
        check("gap_pulses", pulses, IW - K + 1);
        check("gap_eols", eols, 1);

        // mid-line restart at column 50
        clear_counts();
        for (int c = 0; c < IW; c++) beat(1'b1, (c == 0) || (c == 50), rnd_col());
        idle(LAT + 3);
        check("sol_mid_pulses", pulses, (50 - K + 1) + (IW - 50 - K + 1));
        check("sol_mid_eols", eols, 0);

        // reset mid-stream: in-flight results dropped, then K fresh columns needed
        for (int c = 0; c < 20; c++) beat(1'b1, c == 0, rnd_col());
        @(posedge clk);
        #1;
        arst      = 1'b1;
        din_valid = 1'b0;
        din_sol   = 1'b0;
        exp_q.delete();
        line_q.delete();
        hold_val  = 0;
        repeat (3) @(posedge clk);
        #1 arst = 1'b0;
        clear_counts();
        t2 = 0;
        for (int c = 0; c < 10; c++) begin
            beat(1'b1, 1'b0, rnd_col());
            if (c == 2) t2 = cyc;
        end
        idle(LAT + 3);
        check("post_rst_pulses", pulses, 10 - K + 1);
        check("post_rst_first_lat", first_cyc - t2, LAT);
        check("post_rst_eols", eols, 0);
        check("leftover_expected", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
